if_prefetch: RTL and testbench
==============================

# if_prefetch

Parametrised instruction-fetch front end for the openmips core, sitting between the instruction ROM port and the IF/ID boundary. It runs a req/ack handshake against a variable-latency ROM and buffers fetched words in a DEPTH-entry queue. It hands one instruction per cycle to ID and redirects on taken branches while preserving an optional MIPS delay slot. The single-cycle, combinational `pc_reg` fetch path cannot tolerate wait states; this block replaces it.

## Interface
Clocking: one clock; reset is asynchronous and active-low (`clk`, `rst`).
- ADDR_W, 32, instruction address width
- DATA_W, 32, instruction word width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset
- DELAY_SLOT, 1, 1 = keep the instruction following a taken branch; 0 = flush it
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- rom_req_o  out  1  fetch request
- rom_addr_o  out  ADDR_W  fetch address; stable while rom_req_o high and unacked
- rom_ack_i  in  1  rom_data_i valid for the outstanding request; may arrive in the request cycle
- rom_data_i  in  DATA_W  fetched word
- stall_i  in  1  ID not consuming this cycle (ctrl stall for IF/ID)
- branch_flag_i  in  1  taken branch decoded from the head instruction
- branch_target_i  in  ADDR_W  branch target address
- id_valid_o  out  1  head entry valid
- id_pc_o  out  ADDR_W  head PC; 0 when empty
- id_inst_o  out  DATA_W  head word; 0 (NOP) when empty
- level_o  out  log2(DEPTH)+1  queue occupancy

## Operation
- Registered state:
  - fetch_pc
  - circular queue of {pc, inst}, DEPTH entries
  - FSM
  - redirect_pending flag plus saved target
- FSM states:
  - IDLE: rom_req_o = (level_o < DEPTH); rom_addr_o = fetch_pc. If the request is issued without ack → WAIT.
  - WAIT: rom_req_o = 1, address held.
  - DROP: rom_req_o = 1, address held; the returned word is discarded.
- On ack in IDLE or WAIT:
  - push {fetch_pc, rom_data_i}
  - fetch_pc += 4 (mod 2^ADDR_W, wraps)
  - → IDLE
- On ack in DROP: no push; → IDLE.
- If redirect_pending at the ack: fetch_pc ← saved target; redirect_pending clears.
- Pop: id_valid_o && !stall_i removes the head.
- A push and a pop in the same cycle leave level unchanged. Space is checked on registered level only, so a full queue plus a simultaneous pop does not issue.
- branch_flag_i is honoured only when id_valid_o && !stall_i; otherwise ignored. When honoured, the head (the branch) is popped and then:
  - DELAY_SLOT=0: flush all entries. WAIT → DROP. fetch_pc ← target; if in DROP, load target at the ack instead.
  - DELAY_SLOT=1, queue holds ≥1 entry after the pop: keep only the new head, flush the rest, then handle the outstanding request and target as for DELAY_SLOT=0.
  - DELAY_SLOT=1, queue empty after the pop: the next word fetched is the delay slot.
    - If in WAIT, stay in WAIT and set redirect_pending (target loads at that ack).
    - If in IDLE, set redirect_pending; the next fetch of fetch_pc is the delay slot, then redirect.
- A branch in the same cycle as a push: the pushed word counts as the youngest entry and is subject to the flush rule.
- rst low at any time:
  - state → IDLE, queue empty, redirect_pending = 0, fetch_pc = RESET_PC
  - rom_req_o = 0 while rst low
  - an in-flight ack is ignored

## Timing
- Reset values: rom_req_o 0, rom_addr_o RESET_PC, id_valid_o 0, id_pc_o 0, id_inst_o 0, level_o 0.
- First rising edge after rst release: rom_req_o = 1 with addr RESET_PC (combinational from IDLE).
- Latency: an ack at edge k makes the entry visible on id_* after edge k (1 cycle). With a zero-wait ROM, throughput is 1 instruction per cycle.
- Branch redirect: the first target request is issued in the cycle after the branch is honoured (DELAY_SLOT=0) or after the delay-slot ack (DELAY_SLOT=1).
- rom_req_o and rom_addr_o never change while a request is unacked, except on reset.

## Test plan
- Zero-wait streaming: rom_ack_i = rom_req_o, stall_i = 0 → id_pc_o 0x0, 0x4, 0x8… on consecutive cycles from cycle 1; level_o ≤ 1.
- Full queue: DEPTH=4, stall_i = 1 → exactly 4 acks accepted, rom_req_o low, level_o = 4; release stall → 0x0–0xC delivered in order and fetching resumes at 0x10.
- Wait states: ack 3 cycles after each request → rom_addr_o constant across the wait; one id_valid_o pulse per 4 cycles.
- Delay slot queued: queue {0x10 branch, 0x14, 0x18}, branch to 0x100 → next id_pc_o = 0x14, 0x18 never appears, next fetch is 0x100.
- Delay slot in flight / DROP:
  - Queue {0x10} with 0x14 in WAIT, branch → 0x14 delivered, then 0x100.
  - DELAY_SLOT=0, same setup → 0x14 discarded, next id_pc_o = 0x100.
- Async reset during WAIT: rst low mid-cycle → rom_req_o, id_valid_o and level_o drop immediately; an ack during reset is ignored; after release the first fetch is RESET_PC.

Source files
------------

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: req/ack ROM handshake feeding a DEPTH-entry {pc, inst} queue,
// one instruction per cycle to ID, taken-branch redirect with optional delay slot.
module if_prefetch #(
  parameter int unsigned        ADDR_W     = 32,
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        DEPTH      = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter bit                 DELAY_SLOT = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      rom_req_o,
  output logic [ADDR_W-1:0]         rom_addr_o,
  input  logic                      rom_ack_i,
  input  logic [DATA_W-1:0]         rom_data_i,
  input  logic                      stall_i,
  input  logic                      branch_flag_i,
  input  logic [ADDR_W-1:0]         branch_target_i,
  output logic                      id_valid_o,
  output logic [ADDR_W-1:0]         id_pc_o,
  output logic [DATA_W-1:0]         id_inst_o,
  output logic [$clog2(DEPTH):0]    level_o
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE  = (PW+1)'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] redir_tgt;
  logic              redir_pend;
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [DATA_W-1:0] inst_q [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       level;

  logic ack, push_raw, push_eff, pop, br, one_left;
  logic br_pend, redirect, keep_next, flush_all;

  assign rom_req_o  = rst && ((state != S_IDLE) || (level != FULL));
  assign rom_addr_o = fetch_pc;
  assign id_valid_o = (level != '0);
  assign id_pc_o    = id_valid_o ? pc_q[rd_ptr]   : '0;
  assign id_inst_o  = id_valid_o ? inst_q[rd_ptr] : '0;
  assign level_o    = level;

  assign ack      = rom_req_o && rom_ack_i;
  assign push_raw = ack && (state != S_DROP);
  assign pop      = id_valid_o && !stall_i;
  assign br       = pop && branch_flag_i;
  assign one_left = (level == ONE);

  // Branch was the only entry and nothing arrives this cycle: the next fetched word is the delay slot.
  assign br_pend   = br && DELAY_SLOT && one_left && !push_raw;
  assign redirect  = br && !br_pend;
  assign keep_next = br && DELAY_SLOT && !one_left;
  assign flush_all = br && !DELAY_SLOT;
  assign push_eff  = push_raw && (!br || (DELAY_SLOT && one_left));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (keep_next) begin
      rd_ptr <= rd_ptr + 1'b1;
      wr_ptr <= rd_ptr + PW'(2);
      level  <= ONE;
    end else if (flush_all) begin
      rd_ptr <= wr_ptr;
      level  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      level <= level + (PW+1)'(push_eff) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) begin
      pc_q[wr_ptr]   <= fetch_pc;
      inst_q[wr_ptr] <= rom_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      fetch_pc   <= RESET_PC;
      redir_pend <= 1'b0;
      redir_tgt  <= RESET_PC;
    end else if (redirect) begin
      // An issued but unacked request keeps its address; its word is dropped and the target loads at the ack.
      if (ack) begin
        fetch_pc   <= branch_target_i;
        redir_pend <= 1'b0;
        state      <= S_IDLE;
      end else if (rom_req_o) begin
        state      <= S_DROP;
        redir_pend <= 1'b1;
        redir_tgt  <= branch_target_i;
      end else begin
        fetch_pc <= branch_target_i;
        state    <= S_IDLE;
      end
    end else begin
      if (br_pend) begin
        redir_pend <= 1'b1;
        redir_tgt  <= branch_target_i;
      end
      if (ack) begin
        state      <= S_IDLE;
        redir_pend <= 1'b0;
        if (redir_pend)
          fetch_pc <= redir_tgt;
        else if (state != S_DROP)
          fetch_pc <= fetch_pc + ADDR_W'(4);
      end else if (rom_req_o && (state == S_IDLE)) begin
        state <= S_WAIT;
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Scoreboard bench for if_prefetch: two instances (delay slot kept / flushed) against a random-latency ROM,
// expected instruction stream derived from program order (sequential PCs, branch redirect rules).
module tb_if_prefetch;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   phase  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen
    localparam bit          DS  = (g == 0);
    localparam logic [31:0] RPC = (g == 0) ? 32'h0 : 32'h0000_0400;

    logic        rom_req, rom_ack, stall, br_flag, id_valid;
    logic [31:0] rom_addr, rom_data, br_tgt, id_pc, id_inst;
    logic [2:0]  level;
    exp_t        exp_q[$];
    logic [31:0] m_next, m_tgt;
    bit          m_redir;
    int          delivered;

    if_prefetch #(
      .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(RPC), .DELAY_SLOT(DS)
    ) dut (
      .clk(clk), .rst(rst),
      .rom_req_o(rom_req), .rom_addr_o(rom_addr), .rom_ack_i(rom_ack), .rom_data_i(rom_data),
      .stall_i(stall), .branch_flag_i(br_flag), .branch_target_i(br_tgt),
      .id_valid_o(id_valid), .id_pc_o(id_pc), .id_inst_o(id_inst), .level_o(level)
    );

    // ROM: random wait states; acks garbage while reset is held
    initial begin : rom
      bit          busy;
      int          wcnt;
      int          mw;
      logic [31:0] held;
      busy = 0; wcnt = 0; held = '0;
      rom_ack = 1'b0; rom_data = '0;
      forever begin
        @(posedge clk); #1;
        if (!rst) begin
          busy = 0;
          rom_ack = 1'b1; rom_data = 32'hDEAD_BEEF;
          @(negedge clk); #1;
          rom_ack = 1'b0;
        end else begin
          if (rom_ack) begin
            rom_ack = 1'b0;
            busy = 0;
          end else if (busy) begin
            check(rom_req && rom_addr == held, "addr_hold", rom_addr, held);
          end
          if (rom_req && !busy) begin
            busy = 1;
            held = rom_addr;
            mw = (phase == 1) ? 0 : 3;
            wcnt = $urandom_range(0, mw);
          end
          if (busy) begin
            if (wcnt == 0) begin
              rom_ack = 1'b1;
              rom_data = rom_word(held);
            end else begin
              wcnt--;
            end
          end
        end
      end
    end

    // Stimulus plus program-order reference model
    initial begin : drv
      logic [31:0] e;
      bit          consume;
      exp_t        x;
      stall = 1'b0; br_flag = 1'b0; br_tgt = '0;
      m_next = RPC; m_redir = 0; m_tgt = '0;
      forever begin
        @(posedge clk); #2;
        if (!rst) begin
          m_next = RPC; m_redir = 0;
          exp_q.delete();
          stall   = 1'($urandom_range(0, 1));
          br_flag = 1'($urandom_range(0, 1));
          br_tgt  = $urandom;
        end else begin
          case (phase)
            1:       stall = 1'b0;
            2:       stall = 1'b1;
            3:       stall = ($urandom_range(0, 9) < 3);
            default: stall = 1'b0;
          endcase
          br_tgt  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                                                : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
          consume = id_valid && !stall;
          br_flag = (phase < 4) && ($urandom_range(0, 6) == 0) && !(consume && m_redir);
          if (consume) begin
            e = m_next;
            x.pc = e;
            x.inst = rom_word(e);
            exp_q.push_back(x);
            if (m_redir) begin
              m_next = m_tgt;
              m_redir = 0;
            end else if (br_flag) begin
              if (DS) begin
                m_next = e + 32'd4;
                m_redir = 1;
                m_tgt = br_tgt;
              end else begin
                m_next = br_tgt;
              end
            end else begin
              m_next = e + 32'd4;
            end
          end
        end
      end
    end

    initial begin : mon
      exp_t x;
      bit   was_rst;
      bit   fin_done;
      int   fill_cyc;
      was_rst = 1; fin_done = 0; fill_cyc = 0;
      delivered = 0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          was_rst = 1;
          check(!rom_req, "rst_req", 32'(rom_req), 32'h0);
          check(!id_valid, "rst_valid", 32'(id_valid), 32'h0);
          check(level == 3'd0, "rst_level", 32'(level), 32'h0);
          check(id_pc == 32'h0, "rst_pc", id_pc, 32'h0);
          check(id_inst == 32'h0, "rst_inst", id_inst, 32'h0);
          check(rom_addr == RPC, "rst_addr", rom_addr, RPC);
        end else begin
          if (was_rst) begin
            check(rom_req && rom_addr == RPC, "first_fetch", rom_addr, RPC);
            was_rst = 0;
          end
          if (level == 3'(DEPTH)) check(!rom_req, "full_no_req", 32'(rom_req), 32'h0);
          check(level <= 3'(DEPTH), "level_range", 32'(level), DEPTH);
          if (phase == 1) check(level <= 3'd1, "stream_level", 32'(level), 32'h1);
          if (phase == 2) begin
            fill_cyc++;
            if (fill_cyc == 30) check(level == 3'(DEPTH) && !rom_req, "fill_full", 32'(level), DEPTH);
          end
          if (!id_valid) check(id_pc == 32'h0 && id_inst == 32'h0, "empty_nop", id_pc | id_inst, 32'h0);
          if (id_valid && !stall) begin
            check(exp_q.size() != 0, "exp_avail", id_pc, 32'h0);
            if (exp_q.size() != 0) begin
              x = exp_q.pop_front();
              check(id_pc == x.pc, "deliver_pc", id_pc, x.pc);
              check(id_inst == x.inst, "deliver_inst", id_inst, x.inst);
              delivered++;
            end
          end
          if (phase == 5 && !fin_done) begin
            fin_done = 1;
            check(exp_q.size() == 0, "scoreboard_drain", 32'(exp_q.size()), 32'h0);
            check(delivered >= 250, "progress", 32'(delivered), 32'd250);
          end
        end
      end
    end
  end

  initial begin
    phase = 1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    repeat (150) @(posedge clk);
    phase = 2;
    repeat (35) @(posedge clk);
    phase = 3;
    repeat (700) @(posedge clk);
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    repeat (700) @(posedge clk);
    phase = 4;
    repeat (40) @(posedge clk);
    phase = 5;
    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
